// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_if
// Brief    : Fetch-side and memory-side signals of the instruction cache.
// Revision : 1.0
// ============================================================================
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Brief    : Two-way set-associative read-only instruction cache, one word per
//            frame, one LRU bit per set, blocking single-word fill.
// Revision : 1.0
// ============================================================================
module icache #(
  parameter int NSETS = 8
) (
  input  logic    CLK,
  input  logic    RST,
  icache_if.slave bus
);
  localparam int IW = $clog2(NSETS);
  localparam int TW = 30 - IW;

  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t           state_q;
  logic [29:0]      fill_addr_q;
  logic [NSETS-1:0] valid0_q;
  logic [NSETS-1:0] valid1_q;
  logic [NSETS-1:0] lru_q;
  logic [TW-1:0]    tag0_q  [NSETS];
  logic [TW-1:0]    tag1_q  [NSETS];
  logic [31:0]      data0_q [NSETS];
  logic [31:0]      data1_q [NSETS];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          match0;
  logic          match1;
  logic          lookup;
  logic          hit;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          victim;
  logic [1:0]    unused_byte_offset;

  assign idx                = bus.imemaddr[IW+1:2];
  assign tag                = bus.imemaddr[31:IW+2];
  assign unused_byte_offset = bus.imemaddr[1:0];

  assign match0 = valid0_q[idx] && (tag0_q[idx] == tag);
  assign match1 = valid1_q[idx] && (tag1_q[idx] == tag);
  assign lookup = bus.imemREN && (state_q == IDLE);
  assign hit    = lookup && (match0 || match1);

  assign bus.ihit     = hit;
  assign bus.imemload = !hit ? 32'd0 : (match0 ? data0_q[idx] : data1_q[idx]);
  // Memory-side outputs depend on state only, never on datapath inputs.
  assign bus.iREN     = (state_q == FILL);
  assign bus.iaddr    = (state_q == FILL) ? {fill_addr_q, 2'b00} : 32'd0;

  assign fill_idx = fill_addr_q[IW-1:0];
  assign fill_tag = fill_addr_q[29:IW];
  assign victim   = !valid0_q[fill_idx] ? 1'b0 :
                    !valid1_q[fill_idx] ? 1'b1 : lru_q[fill_idx];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
      valid0_q    <= '0;
      valid1_q    <= '0;
      lru_q       <= '0;
    end else if (state_q == IDLE) begin
      if (hit) begin
        lru_q[idx] <= match0;
      end else if (lookup) begin
        fill_addr_q <= bus.imemaddr[31:2];
        state_q     <= FILL;
      end
    end else if (!bus.iwait) begin
      if (victim) begin
        valid1_q[fill_idx] <= 1'b1;
        tag1_q[fill_idx]   <= fill_tag;
        data1_q[fill_idx]  <= bus.iload;
      end else begin
        valid0_q[fill_idx] <= 1'b1;
        tag0_q[fill_idx]   <= fill_tag;
        data0_q[fill_idx]  <= bus.iload;
      end
      lru_q[fill_idx] <= ~victim;
      state_q         <= IDLE;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache
// Brief    : Self-checking bench for icache: directed vector table, directed
//            multi-cycle sequences and random traffic against a word-level model.
// Revision : 1.0
// ============================================================================
module tb_icache;
  localparam int NSETS = 8;
  localparam int IW    = $clog2(NSETS);

  logic CLK;
  logic RST;
  icache_if bus ();

  icache #(.NSETS(NSETS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each way remembers the full word address it holds.
  bit          m_v   [2][NSETS];
  logic [29:0] m_wa  [2][NSETS];
  logic [31:0] m_d   [2][NSETS];
  bit          m_lru [NSETS];
  bit          m_fill = 1'b0;
  logic [29:0] m_fa   = '0;

  logic        o_hit;
  logic [31:0] o_load;
  logic        o_iren;
  logic [31:0] o_iaddr;

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    if (wa == 30'd0) return 32'h2001_0005;
    return {wa[13:0], 2'b11, wa[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst_v, input bit ren, input logic [31:0] a,
                      input bit wt, input bit check_en);
    int  s;
    int  fs;
    int  way;
    int  vic;
    bit  hit;
    s   = int'(a[IW+1:2]);
    hit = 1'b0;
    way = 0;
    if (!m_fill && ren) begin
      for (int w = 1; w >= 0; w--) begin
        if (m_v[w][s] && m_wa[w][s] == a[31:2]) begin
          hit = 1'b1;
          way = w;
        end
      end
    end
    RST          = rst_v;
    bus.imemREN  = ren;
    bus.imemaddr = a;
    bus.iwait    = wt;
    bus.iload    = mem_word(m_fa);
    @(negedge CLK);
    o_hit   = bus.ihit;
    o_load  = bus.imemload;
    o_iren  = bus.iREN;
    o_iaddr = bus.iaddr;
    if (check_en) begin
      chk("model_ihit", {31'd0, o_hit}, {31'd0, hit});
      chk("model_imemload", o_load, hit ? m_d[way][s] : 32'd0);
      chk("model_iREN", {31'd0, o_iren}, {31'd0, m_fill});
      chk("model_iaddr", o_iaddr, m_fill ? {m_fa, 2'b00} : 32'd0);
    end
    @(posedge CLK);
    if (rst_v) begin
      m_fill = 1'b0;
      m_fa   = '0;
      for (int i = 0; i < NSETS; i++) begin
        m_v[0][i] = 1'b0;
        m_v[1][i] = 1'b0;
        m_lru[i]  = 1'b0;
      end
    end else if (!m_fill) begin
      if (hit) begin
        m_lru[s] = (way == 0);
      end else if (ren) begin
        m_fill = 1'b1;
        m_fa   = a[31:2];
      end
    end else if (!wt) begin
      fs  = int'(m_fa[IW-1:0]);
      vic = !m_v[0][fs] ? 0 : (!m_v[1][fs] ? 1 : int'(m_lru[fs]));
      m_v[vic][fs]  = 1'b1;
      m_wa[vic][fs] = m_fa;
      m_d[vic][fs]  = mem_word(m_fa);
      m_lru[fs]     = (vic == 0);
      m_fill        = 1'b0;
    end
    #1;
  endtask

  task automatic fill(input logic [31:0] a);
    step(1'b0, 1'b1, a, 1'b0, 1'b1);
    step(1'b0, 1'b1, a, 1'b0, 1'b1);
  endtask

  typedef struct {
    bit          ren;
    logic [31:0] addr;
    bit          wt;
    bit          e_hit;
    logic [31:0] e_load;
    bit          e_iren;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] ra;
    // Idle after reset, then a 2-wait-state fill of 0x0 and same-cycle re-reads.
    tbl[0]  = '{1'b0, 32'h40, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 32'h44, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    tbl[2]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0};
    tbl[3]  = '{1'b0, 32'h80, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    tbl[4]  = '{1'b0, 32'h04, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0};
    tbl[5]  = '{1'b1, 32'h00, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    tbl[6]  = '{1'b1, 32'h00, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0};
    tbl[7]  = '{1'b1, 32'h00, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0};
    tbl[8]  = '{1'b1, 32'h00, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
    tbl[9]  = '{1'b1, 32'h00, 1'b0, 1'b1, 32'h2001_0005, 1'b0, 32'd0};
    tbl[10] = '{1'b1, 32'h02, 1'b0, 1'b1, 32'h2001_0005, 1'b0, 32'd0};
    tbl[11] = '{1'b1, 32'h00, 1'b1, 1'b1, 32'h2001_0005, 1'b0, 32'd0};

    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, tbl[i].ren, tbl[i].addr, tbl[i].wt, 1'b1);
      chk($sformatf("vec%0d_ihit", i), {31'd0, o_hit}, {31'd0, tbl[i].e_hit});
      chk($sformatf("vec%0d_imemload", i), o_load, tbl[i].e_load);
      chk($sformatf("vec%0d_iREN", i), {31'd0, o_iren}, {31'd0, tbl[i].e_iren});
      chk($sformatf("vec%0d_iaddr", i), o_iaddr, tbl[i].e_iaddr);
    end

    // LRU conflict in set 0: 0x040 must evict 0x020, not the recently read 0x000.
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    fill(32'h000);
    fill(32'h020);
    step(1'b0, 1'b1, 32'h000, 1'b0, 1'b1);
    chk("lru_read0_hit", {31'd0, o_hit}, 32'd1);
    fill(32'h040);
    step(1'b0, 1'b1, 32'h000, 1'b0, 1'b1);
    chk("lru_keep0_hit", {31'd0, o_hit}, 32'd1);
    chk("lru_keep0_data", o_load, 32'h2001_0005);
    step(1'b0, 1'b1, 32'h040, 1'b0, 1'b1);
    chk("lru_new40_hit", {31'd0, o_hit}, 32'd1);
    step(1'b0, 1'b1, 32'h020, 1'b1, 1'b1);
    chk("lru_evicted20_miss", {31'd0, o_hit}, 32'd0);
    step(1'b0, 1'b1, 32'h020, 1'b0, 1'b1);
    chk("lru_evicted20_iREN", {31'd0, o_iren}, 32'd1);
    chk("lru_evicted20_iaddr", o_iaddr, 32'h020);

    // Address change during FILL is ignored until the fill completes.
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h104, 1'b1, 1'b1);
    chk("midfill_iaddr_held", o_iaddr, 32'h100);
    step(1'b0, 1'b1, 32'h104, 1'b0, 1'b1);
    chk("midfill_iaddr_done", o_iaddr, 32'h100);
    step(1'b0, 1'b1, 32'h104, 1'b0, 1'b1);
    chk("midfill_104_miss", {31'd0, o_hit}, 32'd0);
    step(1'b0, 1'b1, 32'h104, 1'b0, 1'b1);
    chk("midfill_104_refill", o_iaddr, 32'h104);
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
    chk("midfill_100_hit", {31'd0, o_hit}, 32'd1);

    // Reset beats a simultaneous fill completion.
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h200, 1'b0, 1'b1);
    chk("rstfill_iREN_before", {31'd0, o_iren}, 32'd1);
    step(1'b0, 1'b0, 32'h200, 1'b0, 1'b1);
    chk("rstfill_iREN_after", {31'd0, o_iren}, 32'd0);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
    chk("rstfill_reread_miss", {31'd0, o_hit}, 32'd0);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      ra = (32'($urandom_range(0, 31)) << 2) | ($urandom & 32'd3);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), ra,
           $urandom_range(0, 1) == 1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/icache.md
# icache

Two-way set-associative, read-only instruction cache sitting directly downstream of the datapath's instruction fetch port. It answers the datapath's `imemREN`/`imemaddr` requests with `ihit`/`imemload`, and on a miss fetches the word from the memory controller over an `iREN`/`iwait` handshake. It is the instruction half of the cache side of `datapath_cache_if`. The block has one block of one word per frame and LRU replacement per set.

## Interface
- `NSETS`, 8: number of sets, power of two ≥ 2; index width `IW = log2(NSETS)`; tag width `TW = 30 - IW`.
- `CLK`  in  1  single clock; all state updates on its rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `imemREN`  in  1  datapath instruction read request.
- `imemaddr`  in  32  datapath fetch address; bits [1:0] are ignored.
- `ihit`  out  1  `imemload` is valid for `imemaddr` this cycle.
- `imemload`  out  32  instruction word; 0 when `ihit` = 0.
- `iREN`  out  1  read request to the memory controller.
- `iaddr`  out  32  word-aligned memory address; 0 when `iREN` = 0.
- `iwait`  in  1  memory busy; a fill completes on a cycle with `iREN` = 1 and `iwait` = 0.
- `iload`  in  32  memory read data, sampled when the fill completes.

## Operation
- Address split: byte offset [1:0], index [IW+1:2], tag [31:IW+2].
- Per set: two ways, each holding `valid`, `tag[TW]` and `data[32]`. Each set also has one `lru` bit naming the way to evict next.
- Hit: `imemREN` = 1, state IDLE, and some way in the indexed set is valid with a matching tag. This asserts `ihit` combinationally and drives that way's data onto `imemload`.
  - If both ways match, which cannot happen in a legal design, way 0 wins.
- On a hit, `lru[set]` is set to the other way at the clock edge.
- FSM states:
  - IDLE: the reset state. On `imemREN` = 1 with no hit, latch `{tag, index}` of `imemaddr` into `fill_addr` and go to FILL.
  - FILL: `iREN` = 1, `iaddr = {fill_addr, 2'b00}`, `ihit` = 0.
    - While `iwait` = 1, stay in FILL.
    - When `iwait` = 0, write the victim way: `valid` = 1, `tag` = latched tag, `data` = `iload`. Set `lru[set]` to the other way and return to IDLE.
- Victim selection, evaluated at fill completion: the first invalid way (way 0 preferred); if both ways are valid, the way named by `lru[set]`.
- Changes on `imemaddr` or `imemREN` during FILL are ignored. The latched fill always completes, and the request is re-evaluated in IDLE.
- Memory writes never reach this cache. It has no coherence and no flush port.

## Timing
- Reset values: state IDLE, all `valid` = 0, all `lru` = 0, `fill_addr` = 0. Consequently `ihit` = 0, `imemload` = 0, `iREN` = 0 and `iaddr` = 0.
  - Data and tag arrays need not be reset.
- Hit latency: 0 cycles. `ihit` is asserted in the same cycle as the request.
- Miss latency: cycle 0 is the miss detect in IDLE. `iREN` rises in cycle 1. If the completing cycle with `iwait` = 0 is cycle k, `ihit` for the same address is asserted in cycle k+1.
  - With zero memory wait states, a miss costs 2 cycles.
- `iREN` and `iaddr` are functions of state only, so they are glitch-free relative to datapath inputs. `ihit` = 0 throughout FILL.
- `RST` asserted mid-FILL: at that edge the block returns to IDLE, no array write occurs, and `iREN` is 0 in the following cycle. `RST` has priority over any simultaneous fill completion.
- `imemREN` = 0 in IDLE: `ihit` = 0, and no state changes except nothing.

## Test plan
- Reset then read 0x0000_0000, with memory returning 0x2001_0005 after 2 wait cycles: `iREN` high for 3 cycles with `iaddr` = 0, then `ihit` = 1 and `imemload` = 0x2001_0005 on the next cycle.
- Re-read 0x0000_0000 and 0x0000_0002 after the fill: `ihit` = 1 in the same cycle for both, `iREN` stays 0, and `imemload` is unchanged.
- Conflict with NSETS = 8: fill 0x000, 0x020, read 0x000, then fill 0x040. The 0x040 fill evicts the 0x020 way (LRU). A subsequent read of 0x000 hits, and a read of 0x020 misses with `iREN` = 1.
- `imemaddr` switched from 0x100 to 0x104 mid-FILL: `iaddr` stays 0x100 until completion. In IDLE, 0x104 then misses and triggers a new FILL.
- `RST` pulsed while in FILL with `iwait` = 0 on the same edge: no line becomes valid, and re-reading that address misses.
- `imemREN` = 0 for 5 cycles after reset: `ihit`, `iREN`, `imemload` and `iaddr` all stay 0.
